// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART receive control path
//
// Purpose : state encoding, supported oversampling ratios and the sample-point
//           offset used by the receive FSM and its edge/bit counter.
// Ports   : none (package).

package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    localparam int unsigned PS_8  = 8;
    localparam int unsigned PS_16 = 16;
    localparam int unsigned PS_32 = 32;

    // The majority vote finishes at edge ps/2+1; the pulse lands one edge later.
    localparam int unsigned SP_OFS = 2;

    // Unsupported ratios fall back to the slowest-safe setting of 8.
    function automatic int unsigned norm_prescale(input int unsigned ps);
        if (ps == PS_16 || ps == PS_32) begin
            return ps;
        end
        return PS_8;
    endfunction

endpackage

// File: rtl/uart_rx_fsm_edge_bit_counter.sv
// rtl/uart_rx_fsm_edge_bit_counter.sv - oversampling edge and frame bit counter
//
// Purpose : counts oversampling edges within a bit (0..ps_q-1) and bits within
//           a frame; bit_cnt advances when edge_cnt wraps.
// Ports   : clk, rst (async, active-low)
//           cnt_en   - advance the edge counter this cycle
//           clr      - force both counters to 0 (wins over cnt_en)
//           ps_q     - latched oversampling ratio
//           edge_cnt - edge index within the current bit
//           bit_cnt  - bit index within the frame
//           bit_done - current edge is the last edge of the bit

module edge_bit_counter #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cnt_en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] ps_q,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic                  bit_done
);

    assign bit_done = (edge_cnt == ps_q - PRESCALE_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (clr) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (cnt_en) begin
            if (bit_done) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + 4'd1;
            end else begin
                edge_cnt <= edge_cnt + PRESCALE_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - UART receiver control state machine
//
// Purpose : detects the start edge, sequences start/data/parity/stop bits,
//           issues one-cycle enables to the sampler, deserializer and
//           checkers, and folds checker results into data_valid/frame_err.
// Ports   : clk, rst (async, active-low)
//           rx_in       - synchronized serial line, idle high
//           par_en      - frame has a parity bit (latched at frame start)
//           prescale    - oversampling ratio 8/16/32 (latched at frame start)
//           strt_glitch, par_err, stp_err - registered checker results
//           edge_cnt, bit_cnt - position within the frame
//           dat_samp_en - sampler enable, high outside IDLE
//           deser_en, strt_chk_en, par_chk_en, stp_chk_en - one-cycle pulses
//           data_valid, frame_err - one-cycle end-of-frame status pulses

module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6,
    parameter int DATA_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  par_en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  strt_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic                  dat_samp_en,
    output logic                  deser_en,
    output logic                  strt_chk_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  data_valid,
    output logic                  frame_err
);

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS);

    rx_state_t             state;
    rx_state_t             state_next;
    logic [PRESCALE_W-1:0] ps_q;
    logic                  pen_q;
    logic                  perr_q;

    logic                  cnt_en;
    logic                  cnt_clr;
    logic                  bit_done;
    logic                  frame_start;
    logic                  pre_sp;
    logic                  frame_done;
    logic                  frame_bad;

    edge_bit_counter #(
        .PRESCALE_W (PRESCALE_W)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .cnt_en   (cnt_en),
        .clr      (cnt_clr),
        .ps_q     (ps_q),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .bit_done (bit_done)
    );

    always_comb begin
        state_next = state;
        cnt_en     = 1'b0;
        cnt_clr    = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (!rx_in) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                cnt_en = 1'b1;
                if (bit_done) begin
                    if (strt_glitch) begin
                        state_next = ST_IDLE;
                        cnt_clr    = 1'b1;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                cnt_en = 1'b1;
                if (bit_done && bit_cnt == LAST_DATA) begin
                    state_next = pen_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                cnt_en = 1'b1;
                if (bit_done) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                cnt_en = 1'b1;
                if (bit_done) begin
                    // Both exits restart the frame counters from zero.
                    cnt_clr    = 1'b1;
                    state_next = rx_in ? ST_IDLE : ST_START;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_clr    = 1'b1;
            end
        endcase
    end

    // A new frame begins on entry to START from IDLE or directly from STOP.
    assign frame_start = (state_next == ST_START) &&
                         (state == ST_IDLE || state == ST_STOP);

    // Enables are registered, so decode the edge just before the sample point;
    // the pulse then appears while edge_cnt equals ps_q/2 + SP_OFS.
    assign pre_sp = (edge_cnt == (ps_q >> 1) + PRESCALE_W'(SP_OFS - 1));

    assign frame_done = (state == ST_STOP) && bit_done;
    assign frame_bad  = stp_err | perr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_q   <= PRESCALE_W'(PS_8);
            pen_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            if (frame_start) begin
                ps_q   <= PRESCALE_W'(norm_prescale(32'(prescale)));
                pen_q  <= par_en;
                perr_q <= 1'b0;
            end else if (state == ST_PARITY && bit_done) begin
                perr_q <= par_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dat_samp_en <= 1'b0;
            deser_en    <= 1'b0;
            strt_chk_en <= 1'b0;
            par_chk_en  <= 1'b0;
            stp_chk_en  <= 1'b0;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            dat_samp_en <= (state_next != ST_IDLE);
            deser_en    <= (state == ST_DATA)   && pre_sp;
            strt_chk_en <= (state == ST_START)  && pre_sp;
            par_chk_en  <= (state == ST_PARITY) && pre_sp;
            stp_chk_en  <= (state == ST_STOP)   && pre_sp;
            data_valid  <= frame_done && !frame_bad;
            frame_err   <= frame_done &&  frame_bad;
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb/tb_uart_rx_fsm.sv - scoreboard testbench for uart_rx_fsm

module tb_uart_rx_fsm;

    localparam int PW = 6;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx_in = 1'b1;
    logic          par_en = 1'b0;
    logic [PW-1:0] prescale = 6'd8;
    logic          strt_glitch = 1'b0;
    logic          par_err = 1'b0;
    logic          stp_err = 1'b0;
    logic [PW-1:0] edge_cnt;
    logic [3:0]    bit_cnt;
    logic          dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
    logic          data_valid, frame_err;

    uart_rx_fsm #(.PRESCALE_W(PW), .DATA_BITS(DB)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .par_en      (par_en),
        .prescale    (prescale),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .dat_samp_en (dat_samp_en),
        .deser_en    (deser_en),
        .strt_chk_en (strt_chk_en),
        .par_chk_en  (par_chk_en),
        .stp_chk_en  (stp_chk_en),
        .data_valid  (data_valid),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit is_err;
        int at;
    } exp_t;
    exp_t sb[$];

    // Checker emulation settings and per-frame expectations.
    bit glitch_cfg = 1'b0;
    bit perr_cfg   = 1'b0;
    bit serr_cfg   = 1'b0;
    int exp_sp     = 6;
    int exp_stop   = 9;
    int n_strt = 0, n_deser = 0, n_par = 0, n_stp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input bit is_err, input int at);
        exp_t e;
        e.is_err = is_err;
        e.at     = at;
        sb.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] d, input int bl, input bit pen);
        rx_in = 1'b0;
        repeat (bl) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            rx_in = d[i];
            repeat (bl) @(negedge clk);
        end
        if (pen) begin
            rx_in = ^d;
            repeat (bl) @(negedge clk);
        end
        rx_in = 1'b1;
        repeat (bl) @(negedge clk);
    endtask

    // Monitor: emulates registered checkers and pops the scoreboard on flags.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            if (strt_chk_en) begin
                n_strt++;
                check("strt_chk_en edge", 32'(edge_cnt), exp_sp);
                check("strt_chk_en bit", 32'(bit_cnt), 0);
                strt_glitch = glitch_cfg;
            end
            if (deser_en) begin
                n_deser++;
                check("deser_en edge", 32'(edge_cnt), exp_sp);
            end
            if (par_chk_en) begin
                n_par++;
                check("par_chk_en edge", 32'(edge_cnt), exp_sp);
                check("par_chk_en bit", 32'(bit_cnt), DB + 1);
                par_err = perr_cfg;
            end
            if (stp_chk_en) begin
                n_stp++;
                check("stp_chk_en edge", 32'(edge_cnt), exp_sp);
                check("stp_chk_en bit", 32'(bit_cnt), exp_stop);
                stp_err = serr_cfg;
            end
            if (data_valid || frame_err) begin
                if (data_valid && frame_err) begin
                    check("both flags", 1, 0);
                end
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected flag: data_valid=%0b frame_err=%0b, expected none (cycle %0d)",
                             data_valid, frame_err, cyc);
                end else begin
                    e = sb.pop_front();
                    check("flag kind frame_err", 32'(frame_err), 32'(e.is_err));
                    check("flag cycle", cyc, e.at);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, " edge_cnt"}, 32'(edge_cnt), 0);
        check({tag, " bit_cnt"}, 32'(bit_cnt), 0);
        check({tag, " enables"},
              32'({dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en}), 0);
        check({tag, " flags"}, 32'({data_valid, frame_err}), 0);
    endtask

    int c0, s_strt, s_deser, s_par, s_stp;

    task automatic snap();
        s_strt  = n_strt;
        s_deser = n_deser;
        s_par   = n_par;
        s_stp   = n_stp;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1: ps=8, no parity, 0x55, good stop: flag 81 cycles after first low sample.
        prescale = 6'd8; par_en = 1'b0; exp_sp = 6; exp_stop = 9;
        snap();
        push_exp(1'b0, cyc + 81);
        send_frame(8'h55, 8, 1'b0);
        repeat (5) @(negedge clk);
        check("t1 deser pulses", n_deser - s_deser, 8);
        check("t1 stp pulses", n_stp - s_stp, 1);
        check("t1 par pulses", n_par - s_par, 0);
        check("t1 pending", sb.size(), 0);

        // 2: ps=16, parity, par_err=1 -> frame_err at (2+8+1)*16+1 = 177.
        prescale = 6'd16; par_en = 1'b1; exp_sp = 10; exp_stop = 10; perr_cfg = 1'b1;
        snap();
        push_exp(1'b1, cyc + 177);
        send_frame(8'hA5, 16, 1'b1);
        repeat (5) @(negedge clk);
        perr_cfg = 1'b0;
        check("t2 par pulses", n_par - s_par, 1);
        check("t2 idle", 32'(dat_samp_en), 0);
        check("t2 pending", sb.size(), 0);

        // 3: glitch start: only strt_chk_en, IDLE after START edge 7.
        prescale = 6'd8; par_en = 1'b0; exp_sp = 6; exp_stop = 9; glitch_cfg = 1'b1;
        snap();
        c0 = cyc;
        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        rx_in = 1'b1;
        while (cyc < c0 + 8) @(negedge clk);
        check("t3 active at edge 7", 32'(dat_samp_en), 1);
        @(negedge clk);
        check("t3 idle after edge 7", 32'(dat_samp_en), 0);
        repeat (15) @(negedge clk);
        glitch_cfg = 1'b0;
        check("t3 strt pulses", n_strt - s_strt, 1);
        check("t3 other pulses", (n_deser - s_deser) + (n_par - s_par) + (n_stp - s_stp), 0);
        check("t3 state idle", 32'(bit_cnt), 0);

        // 4: ps=32, stop error then a clean frame; each 10*32+1 = 321 cycles.
        prescale = 6'd32; exp_sp = 18; serr_cfg = 1'b1;
        push_exp(1'b1, cyc + 321);
        send_frame(8'h3C, 32, 1'b0);
        serr_cfg = 1'b0;
        repeat (10) @(negedge clk);
        push_exp(1'b0, cyc + 321);
        send_frame(8'hC3, 32, 1'b0);
        repeat (5) @(negedge clk);
        check("t4 pending", sb.size(), 0);

        // 5: back-to-back at ps=8: second flag 80 cycles (one frame period) after first.
        prescale = 6'd8; exp_sp = 6;
        c0 = cyc;
        push_exp(1'b0, c0 + 81);
        push_exp(1'b0, c0 + 161);
        send_frame(8'h12, 8, 1'b0);
        send_frame(8'h34, 8, 1'b0);
        repeat (5) @(negedge clk);
        check("t5 pending", sb.size(), 0);

        // 6: reset at DATA bit 4 edge 3, then a fresh frame with prescale=12 (acts as 8).
        c0 = cyc;
        rx_in = 1'b0;
        @(negedge clk);
        rx_in = 1'b1;
        while (cyc < c0 + 36) @(negedge clk);
        check("t6 bit before reset", 32'(bit_cnt), 4);
        check("t6 edge before reset", 32'(edge_cnt), 3);
        rst = 1'b0;
        #1;
        check_all_zero("t6 async reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("t6 after release");
        prescale = 6'd12;
        push_exp(1'b0, cyc + 81);
        send_frame(8'h96, 8, 1'b0);
        repeat (5) @(negedge clk);
        check("t6 pending", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
